// File: rtl/layer_bias_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_bias_pkg
// Purpose  : Shared defaults for the bias/accumulate layer stage: lane width,
//            accumulator width, 18-bit saturation limits and the helper that
//            locates a lane inside a packed lane vector.
// Revision : 1.0 - initial release
// ============================================================================
package layer_bias_pkg;

    localparam int DATA_W  = 18;
    localparam int ACC_W   = 24;

    // Saturation limits for a DATA_W-bit two's complement lane.
    localparam int SAT_MAX = (2 ** (DATA_W - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DATA_W - 1));

    // Low bit position of lane `lane` in a vector packed lane 0 first.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bias_acc_lane.sv
`default_nettype none
// ============================================================================
// Module   : bias_acc_lane
// Purpose  : One lane of the bias accumulator. Holds the running partial sum,
//            seeds it with the bias on the first pass, and presents the
//            clamped (and optionally ReLU'd) result of the current beat plus
//            a flag showing that the clamp engaged.
// Config   : BIAS_ACC_RELU_EN - when defined, negative results output 0.
// Revision : 1.0 - initial release
// ============================================================================
import layer_bias_pkg::*;

module bias_acc_lane #(
    parameter int DATA_W   = layer_bias_pkg::DATA_W,
    parameter int ACC_W    = layer_bias_pkg::ACC_W,
    parameter int LANE_MAX = SAT_MAX,
    parameter int LANE_MIN = SAT_MIN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              use_bias,
    input  logic [DATA_W-1:0] in_lane,
    input  logic [DATA_W-1:0] bias_lane,
    output logic [DATA_W-1:0] result,
    output logic              sat
);

    localparam logic signed [ACC_W-1:0]  HI   = ACC_W'(LANE_MAX);
    localparam logic signed [ACC_W-1:0]  LO   = ACC_W'(LANE_MIN);
    localparam logic        [DATA_W-1:0] HI_D = DATA_W'(LANE_MAX);
    localparam logic        [DATA_W-1:0] LO_D = DATA_W'(LANE_MIN);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;

    assign in_ext   = {{(ACC_W - DATA_W){in_lane[DATA_W-1]}}, in_lane};
    assign bias_ext = {{(ACC_W - DATA_W){bias_lane[DATA_W-1]}}, bias_lane};

    // Sum for this beat, then clamp to the lane range and apply ReLU if built in.
    always_comb begin
        base   = use_bias ? bias_ext : acc;
        sum    = base + in_ext;
        result = sum[DATA_W-1:0];
        sat    = 1'b0;
        if (sum > HI) begin
            result = HI_D;
            sat    = 1'b1;
        end else if (sum < LO) begin
            result = LO_D;
            sat    = 1'b1;
        end
`ifdef BIAS_ACC_RELU_EN
        if (result[DATA_W-1]) begin
            result = '0;
        end
`endif
    end

    // Running partial sum; its value after the final pass is never read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bias_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : bias_accum_stage
// Purpose  : Accumulates N_PASSES partial-sum beats per output pixel, seeded
//            by the per-lane bias, saturates each lane to DATA_W bits and
//            hands the result on through a one-entry valid/ready register.
//            Only the final beat of a pixel can be held off by a full output.
// Config   : BIAS_ACC_RELU_EN - when defined, negative results output 0.
// Revision : 1.0 - initial release
// ============================================================================
import layer_bias_pkg::*;

module bias_accum_stage #(
    parameter int N_adder_tree  = 16,
    parameter int DATA_W        = layer_bias_pkg::DATA_W,
    parameter int N_PASSES      = 4,
    parameter int ACC_W         = layer_bias_pkg::ACC_W,
    localparam int PASS_W       = (N_PASSES > 1) ? $clog2(N_PASSES) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    input  logic [N_adder_tree*DATA_W-1:0] bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic [PASS_W-1:0]              pass_idx,
    output logic                           sat_flag
);

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N_PASSES - 1);
    localparam int                LANE_MAX  = (2 ** (DATA_W - 1)) - 1;
    localparam int                LANE_MIN  = -(2 ** (DATA_W - 1));

    logic                           is_first;
    logic                           is_last;
    logic                           accept;
    logic                           final_accept;
    logic [N_adder_tree*DATA_W-1:0] lane_result;
    logic [N_adder_tree-1:0]        lane_sat;

    // With N_PASSES==1 both flags are always true, so the bias seeds the
    // single (final) beat as well.
    assign is_first     = (pass_idx == '0);
    assign is_last      = (pass_idx == LAST_PASS);

    // Only the final beat needs the output slot; no path from in_valid.
    assign in_ready     = !(is_last && out_valid && !out_ready);
    assign accept       = in_valid && in_ready;
    assign final_accept = accept && is_last;

    generate
        for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
            bias_acc_lane #(
                .DATA_W   (DATA_W),
                .ACC_W    (ACC_W),
                .LANE_MAX (LANE_MAX),
                .LANE_MIN (LANE_MIN)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .accept    (accept),
                .use_bias  (is_first),
                .in_lane   (in_data[lane_lo(i, DATA_W) +: DATA_W]),
                .bias_lane (bias[lane_lo(i, DATA_W) +: DATA_W]),
                .result    (lane_result[lane_lo(i, DATA_W) +: DATA_W]),
                .sat       (lane_sat[i])
            );
        end
    endgenerate

    // Beat counter: advances on every accepted beat, wraps after the final pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_idx <= '0;
        end else if (accept) begin
            pass_idx <= is_last ? '0 : pass_idx + 1'b1;
        end
    end

    // Output register: a final beat reloads it even while it is being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (final_accept) begin
            out_valid <= 1'b1;
            out_data  <= lane_result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky record of any lane clamping on a final pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (final_accept && |lane_sat) begin
            sat_flag <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bias_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_accum_stage
// Purpose  : Directed and randomised self-checking bench for bias_accum_stage
//            (16 lanes, 18-bit data, 4 passes).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_bias_accum_stage;

    localparam int N  = 16;
    localparam int W  = 18;
    localparam int P  = 4;
    localparam int PW = 2;

    typedef logic [N*W-1:0] vec_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    vec_t          in_data   = '0;
    vec_t          bias      = '0;
    logic          in_ready;
    logic          out_valid;
    logic          sat_flag;
    vec_t          out_data;
    logic [PW-1:0] pass_idx;

    int vectors     = 0;
    int miscompares = 0;

    // random-phase reference model
    int   m_acc [N];
    int   m_pass   = 0;
    bit   m_ov     = 1'b0;
    bit   m_sat    = 1'b0;
    vec_t m_out    = '0;
    int   produced = 0;
    int   cycles   = 0;

    bias_accum_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pass_idx  (pass_idx),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input vec_t obs, input vec_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // lane i = base + i*step
    function automatic vec_t fill(input int base, input int step);
        vec_t v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(base + i * step);
        return v;
    endfunction

    function automatic int lane_of(input vec_t v, input int i);
        logic signed [W-1:0] t;
        t = v[i*W +: W];
        return int'(t);
    endfunction

    function automatic int clampv(input int s, output bit hit);
        int r;
        hit = 1'b0;
        r   = s;
        if (s > 131071) begin
            r = 131071;
            hit = 1'b1;
        end else if (s < -131072) begin
            r = -131072;
            hit = 1'b1;
        end
`ifdef BIAS_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    function automatic int rnd_val();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 262143)) - 131072;
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input vec_t d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check_bit("beat_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t exp_v;
        bit   hit;
        bit   exp_ready;
        int   d;
        int   b;

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_vec("rst_out_data", out_data, '0);
        check_int("rst_pass_idx", int'(pass_idx), 0);
        check_bit("rst_sat_flag", sat_flag, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // ---------------- basic pixel: bias 100+i, beats 10..40 -> 200+i
        out_ready = 1'b1;
        bias = fill(100, 1);
        beat(fill(10, 0));
        check_int("t1_pass_after_1", int'(pass_idx), 1);
        beat(fill(20, 0));
        beat(fill(30, 0));
        check_int("t1_pass_after_3", int'(pass_idx), 3);
        check_bit("t1_no_early_valid", out_valid, 1'b0);
        beat(fill(40, 0));
        check_bit("t1_out_valid", out_valid, 1'b1);
        check_vec("t1_out_data", out_data, fill(200, 1));
        check_int("t1_pass_wrap", int'(pass_idx), 0);
        check_bit("t1_sat_flag", sat_flag, 1'b0);
        tick();
        check_bit("t1_drained", out_valid, 1'b0);

        // ---------------- negative result: bias -500, beats 100x4
        bias = fill(-500, 0);
        repeat (4) beat(fill(100, 0));
`ifdef BIAS_ACC_RELU_EN
        check_vec("t2_neg_result", out_data, fill(0, 0));
`else
        check_vec("t2_neg_result", out_data, fill(-100, 0));
`endif
        check_bit("t2_no_sat", sat_flag, 1'b0);

        // ---------------- positive saturation, sticky flag
        bias = fill(0, 0);
        repeat (4) beat(fill(131071, 0));
        check_vec("t3_pos_clamp", out_data, fill(131071, 0));
        check_bit("t3_sat_set", sat_flag, 1'b1);
        bias = fill(100, 1);
        beat(fill(10, 0));
        beat(fill(20, 0));
        beat(fill(30, 0));
        beat(fill(40, 0));
        check_vec("t3_normal_after_sat", out_data, fill(200, 1));
        check_bit("t3_sat_sticky", sat_flag, 1'b1);
        bias = fill(0, 0);
        repeat (4) beat(fill(-131072, 0));
`ifdef BIAS_ACC_RELU_EN
        check_vec("t3_neg_clamp", out_data, fill(0, 0));
`else
        check_vec("t3_neg_clamp", out_data, fill(-131072, 0));
`endif
        tick();

        // ---------------- backpressure: two pixels with out_ready low
        out_ready = 1'b0;
        bias = fill(0, 0);
        repeat (4) beat(fill(1, 1));
        check_bit("t4_a_valid", out_valid, 1'b1);
        check_vec("t4_a_data", out_data, fill(4, 4));
        beat(fill(2, 0));
        bias = fill(7777, 3);  // must not be sampled on later passes
        beat(fill(2, 0));
        beat(fill(2, 0));
        check_int("t4_pass_at_final", int'(pass_idx), 3);
        in_valid = 1'b1;
        in_data  = fill(2, 0);
        #1;
        check_bit("t4_final_stalled", in_ready, 1'b0);
        repeat (3) begin
            tick();
            check_bit("t4_hold_ready", in_ready, 1'b0);
            check_bit("t4_hold_valid", out_valid, 1'b1);
            check_vec("t4_hold_data", out_data, fill(4, 4));
            check_int("t4_hold_pass", int'(pass_idx), 3);
        end
        out_ready = 1'b1;
        #1;
        check_bit("t4_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_bit("t4_reload_valid", out_valid, 1'b1);
        check_vec("t4_b_data", out_data, fill(8, 0));
        check_int("t4_b_pass_wrap", int'(pass_idx), 0);
        tick();
        check_bit("t4_b_drained", out_valid, 1'b0);

        // ---------------- reset mid-pixel
        bias = fill(0, 0);
        beat(fill(5, 0));
        beat(fill(5, 0));
        check_int("t5_pass_mid", int'(pass_idx), 2);
        rst_n = 1'b0;
        #2;
        check_bit("t5_rst_valid", out_valid, 1'b0);
        check_vec("t5_rst_data", out_data, '0);
        check_int("t5_rst_pass", int'(pass_idx), 0);
        check_bit("t5_rst_sat", sat_flag, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (4) beat(fill(1, 0));
        check_bit("t5_fresh_valid", out_valid, 1'b1);
        check_vec("t5_fresh_data", out_data, fill(4, 0));
        check_bit("t5_fresh_sat", sat_flag, 1'b0);
        tick();

        // ---------------- random traffic against the reference model
        m_out = fill(4, 0);
        while (produced < 1000 && cycles < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                in_data[i*W +: W] = W'(rnd_val());
                bias[i*W +: W]    = W'(rnd_val());
            end
            #1;
            exp_ready = !(m_pass == P - 1 && m_ov && !out_ready);
            check_bit("rnd_in_ready", in_ready, exp_ready);
            check_bit("rnd_out_valid", out_valid, m_ov);
            if (m_ov) check_vec("rnd_out_data", out_data, m_out);
            check_int("rnd_pass_idx", int'(pass_idx), m_pass);
            check_bit("rnd_sat_flag", sat_flag, m_sat);

            if (m_ov && out_ready) m_ov = 1'b0;
            if (in_valid && exp_ready) begin
                for (int i = 0; i < N; i++) begin
                    d = lane_of(in_data, i);
                    b = lane_of(bias, i);
                    if (m_pass == 0) m_acc[i] = b + d;
                    else             m_acc[i] = m_acc[i] + d;
                end
                if (m_pass == P - 1) begin
                    exp_v = '0;
                    for (int i = 0; i < N; i++) begin
                        exp_v[i*W +: W] = W'(clampv(m_acc[i], hit));
                        if (hit) m_sat = 1'b1;
                    end
                    m_out  = exp_v;
                    m_ov   = 1'b1;
                    m_pass = 0;
                    produced++;
                end else begin
                    m_pass++;
                end
            end
            tick();
            cycles++;
        end
        check_int("rnd_pixels_done", produced, 1000);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
